// File: rtl/hvsync_ram_subsystem.sv
// Video timing generator (256x240 visible, 309x262 total) plus a small
// single-port synchronous RAM shared by the renderer and the CPU.
// Address multiplexing between the two callers happens outside this block.
module hvsync_ram_subsystem #(
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int RAM_DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [8:0]                hpos,
    output logic [8:0]                vpos,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      display_on,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    input  logic [RAM_DATA_WIDTH-1:0] ram_din,
    input  logic                      ram_we,
    output logic [RAM_DATA_WIDTH-1:0] ram_dout
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

    localparam logic [8:0] H_DISPLAY    = 9'd256;
    localparam logic [8:0] H_SYNC_START = 9'd263;
    localparam logic [8:0] H_SYNC_END   = 9'd285;
    localparam logic [8:0] H_MAX        = 9'd308;

    localparam logic [8:0] V_DISPLAY    = 9'd240;
    localparam logic [8:0] V_SYNC_START = 9'd254;
    localparam logic [8:0] V_SYNC_END   = 9'd256;
    localparam logic [8:0] V_MAX        = 9'd261;

    logic [8:0]                hpos_r;
    logic [8:0]                vpos_r;
    logic                      hsync_r;
    logic                      vsync_r;
    logic [RAM_DATA_WIDTH-1:0] ram_dout_r;
    logic [RAM_DATA_WIDTH-1:0] mem_r [RAM_DEPTH];

    // Inclusive unsigned window test used by both sync decoders.
    function automatic logic in_window(input logic [8:0] val,
                                       input logic [8:0] lo,
                                       input logic [8:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    // Beam counters: hpos every clock, vpos on line end, both wrap at frame end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos_r <= 9'd0;
            vpos_r <= 9'd0;
        end else if (hpos_r == H_MAX) begin
            hpos_r <= 9'd0;
            if (vpos_r == V_MAX) begin
                vpos_r <= 9'd0;
            end else begin
                vpos_r <= vpos_r + 9'd1;
            end
        end else begin
            hpos_r <= hpos_r + 9'd1;
            vpos_r <= vpos_r;
        end
    end

    // Sync pulses decoded from the pre-update counters, so they lag the beam by one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_r <= 1'b0;
            vsync_r <= 1'b0;
        end else begin
            hsync_r <= in_window(hpos_r, H_SYNC_START, H_SYNC_END);
            vsync_r <= in_window(vpos_r, V_SYNC_START, V_SYNC_END);
        end
    end

    // RAM array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_r[ram_addr] <= ram_din;
        end
    end

    // Registered read port; a same-address write in this cycle yields the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_dout_r <= {RAM_DATA_WIDTH{1'b0}};
        end else begin
            ram_dout_r <= mem_r[ram_addr];
        end
    end

    assign hpos       = hpos_r;
    assign vpos       = vpos_r;
    assign hsync      = hsync_r;
    assign vsync      = vsync_r;
    assign ram_dout   = ram_dout_r;
    assign display_on = (hpos_r < H_DISPLAY) && (vpos_r < V_DISPLAY);

endmodule

// File: tb/tb_hvsync_ram_subsystem.sv
// Bench for hvsync_ram_subsystem: a time-based reference model (beam position
// derived from clocks elapsed since reset release, RAM as a plain array) is
// compared against the DUT every cycle, alongside directed literal checks.
module tb_hvsync_ram_subsystem;

    localparam int LINE_CLKS  = 309;
    localparam int FRAME_LNS  = 262;
    localparam int FRAME_CLKS = LINE_CLKS * FRAME_LNS;

    logic        clk;
    logic        reset;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        hsync;
    logic        vsync;
    logic        display_on;
    logic [5:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout;

    int vectors;
    int miscompares;

    hvsync_ram_subsystem #(.RAM_ADDR_WIDTH(6), .RAM_DATA_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            if (miscompares <= 25)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: clocks since reset release and a mirror of the RAM.
    int          t;
    logic [15:0] mem_m [64];
    logic        valid_m [64];
    logic [15:0] exp_dout;
    logic        exp_dv;

    initial begin
        for (int i = 0; i < 64; i++) valid_m[i] = 1'b0;
    end

    always @(posedge clk) begin
        if (!reset) begin
            t        <= 0;
            exp_dout <= 16'h0000;
            exp_dv   <= 1'b1;
        end else begin
            t        <= t + 1;
            exp_dout <= mem_m[ram_addr];
            exp_dv   <= valid_m[ram_addr];
        end
        if (ram_we) begin
            mem_m[ram_addr]   <= ram_din;
            valid_m[ram_addr] <= 1'b1;
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        int p, q, eh, ev, pv, ph;
        if (!reset) begin
            chk("rst_hpos", {23'd0, hpos}, 32'd0);
            chk("rst_vpos", {23'd0, vpos}, 32'd0);
            chk("rst_hsync", {31'd0, hsync}, 32'd0);
            chk("rst_vsync", {31'd0, vsync}, 32'd0);
            chk("rst_dout", {16'd0, ram_dout}, 32'd0);
        end else begin
            p  = t % FRAME_CLKS;
            eh = p % LINE_CLKS;
            ev = p / LINE_CLKS;
            q  = (p + FRAME_CLKS - 1) % FRAME_CLKS;
            ph = q % LINE_CLKS;
            pv = q / LINE_CLKS;
            chk("m_hpos", {23'd0, hpos}, eh);
            chk("m_vpos", {23'd0, vpos}, ev);
            chk("m_disp", {31'd0, display_on}, ((eh < 256) && (ev < 240)) ? 32'd1 : 32'd0);
            chk("m_hsync", {31'd0, hsync}, (t != 0 && ph >= 263 && ph <= 285) ? 32'd1 : 32'd0);
            chk("m_vsync", {31'd0, vsync}, (t != 0 && pv >= 254 && pv <= 256) ? 32'd1 : 32'd0);
            if (exp_dv) chk("m_dout", {16'd0, ram_dout}, {16'd0, exp_dout});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ram();
        ram_addr = 6'($urandom);
        ram_din  = 16'($urandom);
        ram_we   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int hs_cnt, hs_first, hs_last, cyc, bad_disp;
        int rise_v, rise_h, fall_v, fall_h, prev_v, prev_h;
        logic prev_vs, wrapped;
        logic [15:0] pat;
        vectors     = 0;
        miscompares = 0;

        // 1: reset held with RAM writes toggling
        reset    = 1'b0;
        ram_addr = 6'd0;
        ram_din  = 16'd0;
        ram_we   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ram_we   = 1'(i);
            ram_addr = 6'($urandom);
            ram_din  = 16'($urandom);
            tick();
        end
        chk("reset_hpos", {23'd0, hpos}, 32'd0);
        chk("reset_dout", {16'd0, ram_dout}, 32'd0);
        ram_we = 1'b0;
        reset  = 1'b1;
        tick();
        chk("first_edge_hpos", {23'd0, hpos}, 32'd1);

        // 2: line wrap and display edge
        for (int i = 0; i < 307; i++) begin
            ram_addr = 6'($urandom);
            if (hpos == 9'd255) chk("disp_at_255", {31'd0, display_on}, 32'd1);
            if (hpos == 9'd256) chk("disp_at_256", {31'd0, display_on}, 32'd0);
            tick();
        end
        chk("line_end_hpos", {23'd0, hpos}, 32'd308);
        chk("line_end_vpos", {23'd0, vpos}, 32'd0);
        tick();
        chk("wrap_hpos", {23'd0, hpos}, 32'd0);
        chk("wrap_vpos", {23'd0, vpos}, 32'd1);

        // 3: hsync width over line 1
        hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < LINE_CLKS; i++) begin
            if (hsync) begin
                hs_cnt = hs_cnt + 1;
                if (hs_first < 0) hs_first = int'(hpos);
                hs_last = int'(hpos);
            end
            tick();
        end
        chk("hsync_width", hs_cnt, 32'd23);
        chk("hsync_first", hs_first, 32'd264);
        chk("hsync_last", hs_last, 32'd286);

        // 5: write, read, read-during-write
        ram_addr = 6'd5; ram_din = 16'hBEEF; ram_we = 1'b1;
        tick();
        ram_we = 1'b0;
        tick();
        chk("ram_read_beef", {16'd0, ram_dout}, 32'h0000BEEF);
        ram_din = 16'h1234; ram_we = 1'b1;
        tick();
        chk("rdw_old", {16'd0, ram_dout}, 32'h0000BEEF);
        ram_we = 1'b0;
        tick();
        chk("rdw_new", {16'd0, ram_dout}, 32'h00001234);

        // 6: fill all words, reset mid-line, read everything back
        for (int a = 0; a < 64; a++) begin
            ram_addr = 6'(a);
            ram_din  = 16'(a * 257) ^ 16'h5A5A;
            ram_we   = 1'b1;
            tick();
        end
        ram_we = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("restart_hpos", {23'd0, hpos}, 32'd0);
        chk("restart_vpos", {23'd0, vpos}, 32'd0);
        cyc = 0;
        for (int a = 0; a < 64; a++) begin
            ram_addr = 6'(a);
            tick();
            cyc = cyc + 1;
            pat = 16'(a * 257) ^ 16'h5A5A;
            chk("persist", {16'd0, ram_dout}, {16'd0, pat});
        end
        chk("after_read_hpos", {23'd0, hpos}, 32'd64);

        // Random RAM traffic while the beam runs; then frame wrap and vsync.
        for (int i = 0; i < 400; i++) begin
            rand_ram();
            tick();
            cyc = cyc + 1;
        end

        bad_disp = 0; rise_v = -1; rise_h = -1; fall_v = -1; fall_h = -1;
        prev_vs = vsync; prev_v = int'(vpos); prev_h = int'(hpos);
        wrapped = 1'b0;
        while (!wrapped && cyc < 90000) begin
            rand_ram();
            tick();
            cyc = cyc + 1;
            if (vpos >= 9'd240 && display_on) bad_disp = bad_disp + 1;
            if (vsync && !prev_vs) begin rise_v = int'(vpos); rise_h = int'(hpos); end
            if (!vsync && prev_vs) begin fall_v = int'(vpos); fall_h = int'(hpos); end
            if (hpos == 9'd0 && vpos == 9'd0) begin
                wrapped = 1'b1;
                chk("pre_wrap_v", prev_v, 32'd261);
                chk("pre_wrap_h", prev_h, 32'd308);
            end else begin
                prev_v = int'(vpos);
                prev_h = int'(hpos);
            end
            prev_vs = vsync;
        end
        chk("frame_wrap_seen", {31'd0, wrapped}, 32'd1);
        chk("frame_period", cyc, FRAME_CLKS);
        chk("vsync_rise_v", rise_v, 32'd254);
        chk("vsync_rise_h", rise_h, 32'd1);
        chk("vsync_fall_v", fall_v, 32'd257);
        chk("vsync_fall_h", fall_h, 32'd1);
        chk("disp_off_bottom", bad_disp, 32'd0);

        for (int i = 0; i < 20; i++) begin
            rand_ram();
            tick();
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hvsync_ram_subsystem.md
Name: hvsync_ram_subsystem

Overview:
Video timing plus shared-memory block for the 8-bit raster pipeline.
- Generates 9-bit beam counters, registered sync pulses and a display-enable flag for a 256x240 visible raster.
- Contains a small single-port synchronous RAM. A sprite/scanline renderer and a CPU share this RAM by time-multiplexing its address bus.
- Both functions run on one clock and share one reset.

Parameters:
RAM_ADDR_WIDTH, 6, RAM address bits; depth = 2^RAM_ADDR_WIDTH words.
RAM_DATA_WIDTH, 16, RAM word width in bits.

Ports:
clk  input  1  system/pixel clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset; asserted when 0.
hpos  output  9  horizontal beam counter, 0..308.
vpos  output  9  vertical beam counter, 0..261.
hsync  output  1  registered horizontal sync, active-high.
vsync  output  1  registered vertical sync, active-high.
display_on  output  1  high when the beam is in the visible area.
ram_addr  input  RAM_ADDR_WIDTH  RAM word address.
ram_din  input  RAM_DATA_WIDTH  RAM write data.
ram_we  input  1  RAM write enable.
ram_dout  output  RAM_DATA_WIDTH  registered RAM read data.

Behaviour:
Timing constants:
- Horizontal: display 256, front porch 7, sync 23, back porch 23.
  - H_SYNC_START = 263, H_SYNC_END = 285, H_MAX = 308.
  - 309 clocks per line.
- Vertical: display 240, bottom porch 14, sync 3, top porch 5.
  - V_SYNC_START = 254, V_SYNC_END = 256, V_MAX = 261.
  - 262 lines per frame; 80958 clocks per frame.

Counters:
- hpos increments every clock.
- When hpos == H_MAX: hpos <= 0, and vpos increments.
- When hpos == H_MAX and vpos == V_MAX: vpos <= 0, so both counters wrap together.
- No other values are reachable after reset.

Sync outputs:
- Registered from the pre-update counters:
  - hsync <= (H_SYNC_START <= hpos <= H_SYNC_END)
  - vsync <= (V_SYNC_START <= vpos <= V_SYNC_END)
- Net effect: hsync is high while the observed hpos is 264..286 (23 clocks per line).
- vsync rises at hpos == 1 of line 254 and falls at hpos == 1 of line 257 (3 lines = 927 clocks).

display_on:
- Combinational: (hpos < 256) && (vpos < 240).
- Not delayed.

Reset (reset == 0, asynchronous):
- hpos = 0, vpos = 0, hsync = 0, vsync = 0, ram_dout = 0.
- RAM array contents are not cleared.
- Reset mid-frame restarts the timing at (0,0) on the first clock after release.

RAM:
- Single port, one access per clock.
- Write: on a clock edge with ram_we = 1, mem[ram_addr] <= ram_din.
- Read: every clock edge, ram_dout <= mem[ram_addr]. One-cycle read latency.
- Read-during-write to the same address returns the OLD contents. The new value is visible on the following cycle's read.
- Address wraps naturally within 2^RAM_ADDR_WIDTH; no out-of-range condition exists.
- No arbitration inside the block. Callers multiplex ram_addr/ram_we externally: the renderer owns the bus on line 260, the CPU owns it on other lines.

Widths:
- Counters are compared as unsigned 9-bit values.
- vpos[8] == 1 marks lines 256..261 (non-rendered); consumers rely on this.

Test Plan:
1. Reset: hold reset = 0 for 5 clocks, with ram_we toggling -> hpos = 0, vpos = 0, hsync = 0, vsync = 0, ram_dout = 0; after release, hpos reads 1 after the first edge.
2. Line wrap: run 308 clocks from reset -> hpos = 308, vpos = 0; next clock -> hpos = 0, vpos = 1. display_on is 1 at hpos = 255 and 0 at hpos = 256.
3. Horizontal sync: over one line, hsync is 1 exactly while hpos is 264..286, i.e. 23 clocks high, 0 elsewhere.
4. Frame wrap and vertical sync:
   - At vpos = 261, hpos = 308, the next clock gives hpos = 0, vpos = 0.
   - The frame period is 80958 clocks.
   - vsync is high from (254,1) through (257,0).
   - display_on is 0 for all vpos >= 240.
5. RAM write/read:
   - Write 16'hBEEF to address 5 (ram_we = 1), then ram_we = 0, ram_addr = 5.
   - -> ram_dout = 16'hBEEF one cycle later.
   - Then write 16'h1234 to address 5 while reading -> ram_dout shows 16'hBEEF that cycle and 16'h1234 the next.
6. RAM persistence and wrap:
   - Write distinct values to addresses 0..63.
   - Pulse reset = 0 mid-line.
   - Read back all 64 words -> all values retained; counters restarted at (0,0).
